// File: rtl/fini_detect_pipe.sv
// fini_detect_pipe: two-stage pipelined replicated-AND fault detector.
// Computes N = K+1 redundant copies of a W-bit AND, flags any disagreement
// between copies, and latches a sticky ALARM state with a saturating error
// counter. Data outputs are zeroed while ALARM is (or is about to be) active.
// Optional build macro: FINI_MAJORITY_CORRECT_EN. When defined and N is odd
// and >= 3, port_c carries the bitwise majority vote replicated into every
// copy, and mismatches are counted and flagged without raising ALARM.
module fini_detect_pipe #(
   parameter int W         = 1,
   parameter int K         = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [(K+1)*W-1:0]     port_a,
   input  logic [(K+1)*W-1:0]     port_b,
   input  logic                   err_clear,
   output logic                   out_valid,
   output logic [(K+1)*W-1:0]     port_c,
   output logic                   port_errorFlag,
   output logic                   alarm,
   output logic [ERR_CNT_W-1:0]   err_count
);

   localparam int N  = K + 1;
   localparam int NW = N * W;

`ifdef FINI_MAJORITY_CORRECT_EN
   // Odd copy counts can never tie on a bit, so every disagreement is correctable.
   localparam bit MAJ_EN = ((N % 2) == 1) && (N >= 3);
`else
   localparam bit MAJ_EN = 1'b0;
`endif

   typedef enum logic {RUN = 1'b0, ALARM = 1'b1} state_t;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      if (&v) return v;
      return v + 1'b1;
   endfunction

`ifdef FINI_MAJORITY_CORRECT_EN
   // Bitwise strict-majority vote across the N copies.
   function automatic logic [W-1:0] maj_vote(input logic [NW-1:0] p);
      logic [W-1:0] res;
      int           cnt;
      res = '0;
      for (int j = 0; j < W; j++) begin
         cnt = 0;
         for (int i = 0; i < N; i++) begin
            if (p[i*W + j]) cnt++;
         end
         res[j] = ((2 * cnt) > N);
      end
      return res;
   endfunction
`endif

   logic [NW-1:0]        prod_p1_q;
   logic                 vld_p1_q;

   state_t               state_q, state_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [NW-1:0]        port_c_q, port_c_d;
   logic                 flag_q, flag_d;

   logic                 mism;
   logic                 mism_beat;
   logic                 raise;
   logic [NW-1:0]        c_src;

   // ---- stage 1: per-copy AND products and their valid bit
   always_ff @(posedge clk) begin
      prod_p1_q <= port_a & port_b;
      if (rst) vld_p1_q <= 1'b0;
      else     vld_p1_q <= in_valid;
   end

   // ---- stage 2: consistency check of copies 1..K against copy 0
   always_comb begin
      mism = 1'b0;
      for (int i = 1; i <= K; i++) begin
         if (prod_p1_q[i*W +: W] != prod_p1_q[0 +: W]) mism = 1'b1;
      end
      mism_beat = vld_p1_q & mism;
      // With majority correction on odd N, no bit can be left without a majority.
      raise     = mism_beat & ~MAJ_EN;
   end

   // Select the data presented on port_c: raw products or the replicated vote.
   always_comb begin
      c_src = prod_p1_q;
`ifdef FINI_MAJORITY_CORRECT_EN
      if (MAJ_EN) c_src = {N{maj_vote(prod_p1_q)}};
`endif
   end

   // Alarm FSM next state, error counter and output beat formation.
   always_comb begin
      state_d     = state_q;
      err_cnt_d   = err_clear ? '0 : err_cnt_q;
      out_valid_d = vld_p1_q;
      flag_d      = mism_beat;
      port_c_d    = '0;

      case (state_q)
         RUN:     if (raise) state_d = ALARM;
         ALARM:   if (err_clear && !raise) state_d = RUN;
         default: state_d = RUN;
      endcase

      // Clear first, then count, so a simultaneous clear and error leaves 1.
      if (mism_beat) err_cnt_d = sat_inc(err_cnt_d);

      if (vld_p1_q && (state_d == RUN)) port_c_d = c_src;
   end

   // Output and control registers; reset discards any beat in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         err_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         port_c_q    <= '0;
         flag_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_cnt_q   <= err_cnt_d;
         out_valid_q <= out_valid_d;
         port_c_q    <= port_c_d;
         flag_q      <= flag_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign port_c         = port_c_q;
   assign port_errorFlag = flag_q;
   assign alarm          = (state_q == ALARM);
   assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_fini_detect_pipe.sv
// Directed testbench for fini_detect_pipe with W=4, K=2 (three copies).
// A second instance with a 2-bit error counter shares the stimulus to
// exercise counter saturation.
module tb_fini_detect_pipe;

   localparam int W  = 4;
   localparam int K  = 2;
   localparam int NW = (K + 1) * W;

   localparam logic [NW-1:0] A_CLEAN = 12'hBBB;
   localparam logic [NW-1:0] B_ALL   = 12'h666;
   localparam logic [NW-1:0] A_FAULT = 12'hBFB;   // copy 1 a=0xF -> p_1=0x6
   localparam logic [NW-1:0] A_ALT   = 12'hCCC;
   localparam logic [NW-1:0] B_ALT   = 12'hAAA;   // 0xC & 0xA = 0x8

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [NW-1:0]   port_a;
   logic [NW-1:0]   port_b;
   logic            err_clear;

   logic            out_valid,  out_valid2;
   logic [NW-1:0]   port_c,     port_c2;
   logic            flag,       flag2;
   logic            alarm,      alarm2;
   logic [7:0]      err_count;
   logic [1:0]      err_count2;

   int checks = 0;
   int errors = 0;

   fini_detect_pipe #(.W(W), .K(K), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .port_a(port_a), .port_b(port_b),
      .err_clear(err_clear), .out_valid(out_valid), .port_c(port_c),
      .port_errorFlag(flag), .alarm(alarm), .err_count(err_count)
   );

   fini_detect_pipe #(.W(W), .K(K), .ERR_CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .port_a(port_a), .port_b(port_b),
      .err_clear(err_clear), .out_valid(out_valid2), .port_c(port_c2),
      .port_errorFlag(flag2), .alarm(alarm2), .err_count(err_count2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [NW-1:0] c,
                          input logic f);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      check({tag, ".port_c"},    32'(port_c),    32'(c));
      check({tag, ".flag"},      32'(flag),      32'(f));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      port_a    = '0;
      port_b    = '0;
      err_clear = 1'b0;
      do_reset();

      // Reset state and idle cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out("idle", 1'b0, '0, 1'b0);
         check("idle.alarm", 32'(alarm), 32'd0);
         check("idle.err_count", 32'(err_count), 32'd0);
      end

`ifdef FINI_MAJORITY_CORRECT_EN
      // Faulty copy 1 is outvoted; flagged and counted but no alarm
      port_a = A_FAULT; port_b = B_ALL; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk_out("maj", 1'b1, 12'h222, 1'b1);
      check("maj.err_count", 32'(err_count), 32'd1);
      check("maj.alarm", 32'(alarm), 32'd0);
      tick();
      check("maj.alarm_next", 32'(alarm), 32'd0);
      check("maj.out_valid_next", 32'(out_valid), 32'd0);
`else
      // Clean beat: 2-cycle latency, all copies agree
      port_a = A_CLEAN; port_b = B_ALL; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("clean.latency", 32'(out_valid), 32'd0);
      tick();
      chk_out("clean", 1'b1, 12'h222, 1'b0);
      check("clean.alarm", 32'(alarm), 32'd0);
      tick();
      check("clean.gap", 32'(out_valid), 32'd0);

      // Second clean pattern
      port_a = A_ALT; port_b = B_ALT; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk_out("alt", 1'b1, 12'h888, 1'b0);

      // Faulty beat: flagged, data suppressed, alarm latched
      port_a = A_FAULT; port_b = B_ALL; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk_out("fault", 1'b1, 12'h000, 1'b1);
      check("fault.err_count", 32'(err_count), 32'd1);
      tick();
      check("fault.alarm", 32'(alarm), 32'd1);
      check("fault.err_count_hold", 32'(err_count), 32'd1);

      // Three clean beats in ALARM: valid but zeroed, no counting
      port_a = A_CLEAN; port_b = B_ALL;
      for (int k = 0; k < 5; k++) begin
         in_valid = (k < 3);
         tick();
         if (k >= 1 && k <= 3) begin
            chk_out("alarm_clean", 1'b1, 12'h000, 1'b0);
            check("alarm_clean.alarm", 32'(alarm), 32'd1);
         end
      end
      check("alarm_clean.err_count", 32'(err_count), 32'd1);

      // Three faulty beats; err_clear coincides with the 3rd at stage 2
      port_a = A_FAULT; port_b = B_ALL;
      for (int k = 0; k < 5; k++) begin
         in_valid  = (k < 3);
         err_clear = (k == 3);
         tick();
         if (k == 1) check("burst.cnt1", 32'(err_count), 32'd2);
         if (k == 2) check("burst.cnt2", 32'(err_count), 32'd3);
         if (k == 3) begin
            chk_out("burst.last", 1'b1, 12'h000, 1'b1);
            check("burst.clr_cnt", 32'(err_count), 32'd1);
            check("burst.clr_alarm", 32'(alarm), 32'd1);
         end
      end
      err_clear = 1'b0;

      // err_clear alone returns to RUN
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("clear.alarm", 32'(alarm), 32'd0);
      check("clear.err_count", 32'(err_count), 32'd0);
      port_a = A_CLEAN; port_b = B_ALL; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk_out("after_clear", 1'b1, 12'h222, 1'b0);
      check("after_clear.alarm", 32'(alarm), 32'd0);

      // Saturation: 5 faulty beats, 2-bit counter holds at 3
      do_reset();
      port_a = A_FAULT; port_b = B_ALL;
      for (int k = 0; k < 6; k++) begin
         in_valid = (k < 5);
         tick();
         if (k >= 1) begin
            check("sat.cnt2", 32'(err_count2), (k >= 3) ? 32'd3 : 32'(k));
            check("sat.cnt8", 32'(err_count), 32'(k));
         end
      end

      // Reset one cycle after a beat discards it
      do_reset();
      port_a = A_CLEAN; port_b = B_ALL; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_out("rst_mid", 1'b0, '0, 1'b0);
      check("rst_mid.alarm", 32'(alarm), 32'd0);
      check("rst_mid.err_count", 32'(err_count), 32'd0);
      tick();
      check("rst_mid.after", 32'(out_valid), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fini_detect_pipe.md
Name: fini_detect_pipe

Overview:
- Parametrised, pipelined successor of the combinational replicated-AND fault-detection gadget.
- Computes K+1 redundant copies of a W-bit bitwise AND (c_i = a_i & b_i) and registers the results.
- Checks all copies for mutual consistency and raises a per-beat error flag.
- Tracks faults in a sticky alarm FSM with a saturating error counter. While the alarm is active, outputs are suppressed (zeroed) so faulty data never propagates.

Parameters:
- W, 1, bit width of one copy.
- K, 2, detection order; the block carries N = K+1 copies.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  port_a/port_b carry a beat this cycle.
- port_a  in  N*W  copy i at bits [i*W +: W].
- port_b  in  N*W  same layout as port_a.
- err_clear  in  1  one-cycle pulse; leave ALARM and clear err_count.
- out_valid  out  1  port_c/port_errorFlag carry a beat.
- port_c  out  N*W  per-copy product, same layout as port_a.
- port_errorFlag  out  1  active-high; the current output beat had mismatching copies.
- alarm  out  1  high while the FSM is in ALARM.
- err_count  out  ERR_CNT_W  number of erroneous beats, saturating.

Behaviour:
- Clock and reset:
  - Single clock domain clk. Reset rst is synchronous and active-high.
  - No backpressure. The block accepts one beat every cycle in_valid is high.
- Reset values:
  - out_valid=0, port_c=0, port_errorFlag=0, alarm=0, err_count=0.
  - FSM state = RUN; all pipeline valid bits = 0.
- Stage 1 (cycle t+1 after in_valid at t):
  - Register p_i = a_i & b_i for every copy i.
  - Register v1 = in_valid.
- Stage 2 (cycle t+2):
  - mism = OR over i=1..K of (p_i != p_0), compared bitwise across all W bits.
  - out_valid = v1.
  - port_errorFlag = v1 & mism.
  - port_c = p when the next state is RUN, otherwise all-zero.
  - When v1=0: port_c=0 and port_errorFlag=0.
- Latency and throughput: fixed 2 cycles from input to output; full throughput of one beat per cycle.
- K=0: mism is constantly 0, so port_errorFlag, alarm and err_count stay 0.
- FSM:
  - RUN -> ALARM on a stage-2 beat with mism=1. That beat's port_c is already zeroed.
  - ALARM -> RUN on err_clear=1 with no concurrent mismatching beat.
  - ALARM with no err_clear: stays in ALARM.
  - In ALARM, out_valid still follows v1, but port_c=0 and port_errorFlag still reports mism.
- err_count:
  - Increments by 1 on each stage-2 beat with mism=1.
  - Saturates at 2^ERR_CNT_W-1 and never wraps.
  - err_clear forces 0.
- Simultaneous err_clear and mismatching beat:
  - The error wins: state stays/enters ALARM.
  - err_count = 1 (clear, then count).
- err_clear in RUN with no error: err_count goes to 0; the FSM stays in RUN.
- rst mid-stream: in-flight beats are discarded, and no out_valid is issued for them.

Optional Feature:
- Macro FINI_MAJORITY_CORRECT_EN.
- When defined, and N is odd and >= 3:
  - port_c carries the bitwise majority vote of p_0..p_K, replicated into all N copies.
  - A mismatch still sets port_errorFlag and increments err_count.
  - The FSM enters ALARM only when some bit position has no strict majority. This cannot happen for odd N, so effectively alarm follows only uncorrectable disagreement (tied bits, which arise only for even N).
  - For even N the macro has no effect.
- When not defined: behaviour exactly as in Behaviour above.

Test Plan:
- Reset, then idle for 5 cycles -> out_valid=0, port_c=0, alarm=0, err_count=0 throughout.
- W=4, K=2: all copies a=0xB, b=0x6, in_valid for 1 cycle -> two cycles later: out_valid=1, port_c=0x222, port_errorFlag=0, alarm=0.
- Same beat with copy 1 a=0xF (p_1=0x6) -> out_valid=1, port_errorFlag=1, port_c=0x000, alarm=1 from the next cycle, err_count=1. Three more clean beats -> port_c=0, err_count stays 1.
- Send 3 faulty beats back-to-back, then pulse err_clear in the same cycle as the 3rd faulty beat reaches stage 2 -> alarm stays 1, err_count=1. Then err_clear alone -> alarm=0, err_count=0, and the next clean beat passes 0x222.
- ERR_CNT_W=2, 5 faulty beats -> err_count sequence 1,2,3,3,3 (no wrap).
- Reset asserted one cycle after an input beat -> no out_valid for that beat, all outputs at their reset values. With FINI_MAJORITY_CORRECT_EN and the faulty-copy-1 beat -> port_c=0x222, port_errorFlag=1, alarm=0.
